// File: rtl/vector_lane_array_alu_if.sv
// Issue/writeback handshake bundle for vector_lane_array_alu.
// master = issuing side, slave = the ALU.
interface vector_lane_array_alu_if #(
  parameter int LANE_NUM = 4,
  parameter int ELEN     = 64,
  parameter int LEN      = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [2:0]               vsew;
  logic                     vm;
  logic [5:0]               opcode;
  logic [1:0]               vec_operand_type;
  logic                     is_mask_operation;
  logic [LANE_NUM-1:0]      mask;
  logic [LANE_NUM*ELEN-1:0] vs1;
  logic [LANE_NUM*ELEN-1:0] vs2;
  logic [LANE_NUM*ELEN-1:0] vd_old;
  logic [LEN-1:0]           imm;
  logic [LEN-1:0]           rs;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANE_NUM*ELEN-1:0] result;
  logic                     out_error;
  logic                     busy;

  modport master (
    output in_valid, vsew, vm, opcode, vec_operand_type, is_mask_operation,
           mask, vs1, vs2, vd_old, imm, rs, out_ready,
    input  in_ready, out_valid, result, out_error, busy
  );

  modport slave (
    input  in_valid, vsew, vm, opcode, vec_operand_type, is_mask_operation,
           mask, vs1, vs2, vd_old, imm, rs, out_ready,
    output in_ready, out_valid, result, out_error, busy
  );
endinterface

// File: rtl/vector_lane_array_alu.sv
// LANE_NUM-lane integer vector ALU with add/sub/carry and multiply-accumulate ops.
// Optional macro VECTOR_LANE_FAST_MUL_EN: single-cycle combinational multiply instead of shift-add.
module vector_lane_array_alu #(
  parameter int LANE_NUM = 4,
  parameter int ELEN     = 64,
  parameter int LEN      = 32
) (
  input logic                   clk,
  input logic                   rst,
  vector_lane_array_alu_if.slave bus
);
  localparam logic [5:0] VECTOR_ADD   = 6'b000000;
  localparam logic [5:0] VECTOR_SUB   = 6'b000010;
  localparam logic [5:0] VECTOR_ADC   = 6'b010000;
  localparam logic [5:0] VECTOR_MADC  = 6'b010001;
  localparam logic [5:0] VECTOR_SBC   = 6'b010010;
  localparam logic [5:0] VECTOR_MSBC  = 6'b010011;
  localparam logic [5:0] VECTOR_MADD  = 6'b101001;
  localparam logic [5:0] VECTOR_MACC  = 6'b101101;
  localparam logic [5:0] VECTOR_NMSAC = 6'b101111;

`ifdef VECTOR_LANE_FAST_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_e;
`endif

  function automatic logic [ELEN-1:0] sew_mask(input logic [6:0] sew_bits);
    logic [ELEN:0] full;
    full = ({{ELEN{1'b0}}, 1'b1} << sew_bits) - {{ELEN{1'b0}}, 1'b1};
    return full[ELEN-1:0];
  endfunction

  state_e                   state_q, state_d;
  logic [LANE_NUM*ELEN-1:0] result_q, result_d;
  logic                     err_q, err_d;
  logic [6:0]               sew_bits_s;
  logic [ELEN-1:0]          sew_m_s, scalar_s;
  logic                     sew_ok_s, op_ok_s, is_mul_s, err_s, in_ready_s, accept_s;
  logic [LANE_NUM*ELEN-1:0] lane_res_s;
  logic [ELEN-1:0]          opa_s [LANE_NUM];
  logic [ELEN-1:0]          opb_s [LANE_NUM];
  logic [ELEN-1:0]          opd_s [LANE_NUM];
  logic [LANE_NUM-1:0]      active_s;
`ifndef VECTOR_LANE_FAST_MUL_EN
  logic [6:0]               cnt_q, cnt_d;
  logic [ELEN-1:0]          mcand_q [LANE_NUM];
  logic [ELEN-1:0]          mcand_d [LANE_NUM];
  logic [ELEN-1:0]          mplier_q [LANE_NUM];
  logic [ELEN-1:0]          mplier_d [LANE_NUM];
  logic [ELEN-1:0]          acc_q [LANE_NUM];
  logic [ELEN-1:0]          acc_d [LANE_NUM];
  logic [LANE_NUM-1:0]      active_q, active_d;
  logic [LANE_NUM*ELEN-1:0] vd_old_q, vd_old_d;
  logic [ELEN-1:0]          sew_m_q, sew_m_d;
  logic                     neg_q, neg_d, mop_q, mop_d;
`endif

  assign in_ready_s    = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign accept_s      = bus.in_valid && in_ready_s;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.out_error = err_q;
  assign bus.busy      = (state_q != S_IDLE);

  // Request decode: element width, opcode legality, scalar broadcast operand
  always_comb begin
    sew_bits_s = 7'd8 << bus.vsew[1:0];
    sew_ok_s   = (bus.vsew[2] == 1'b0) && ({25'd0, sew_bits_s} <= 32'(ELEN));
    sew_m_s    = sew_mask(sew_bits_s);
    case (bus.opcode)
      VECTOR_ADD, VECTOR_SUB, VECTOR_ADC, VECTOR_SBC, VECTOR_MADC, VECTOR_MSBC,
      VECTOR_MACC, VECTOR_NMSAC, VECTOR_MADD: op_ok_s = 1'b1;
      default:                                op_ok_s = 1'b0;
    endcase
    is_mul_s = (bus.opcode == VECTOR_MACC) || (bus.opcode == VECTOR_NMSAC) ||
               (bus.opcode == VECTOR_MADD);
    err_s    = !(sew_ok_s && op_ok_s);
    if (bus.vec_operand_type == 2'b01) begin
      scalar_s = ELEN'($signed(bus.rs));
    end else begin
      scalar_s = ELEN'($signed(bus.imm));
    end
  end

  // Per-lane single-cycle result; inactive lanes pass vd_old through undisturbed
  always_comb begin
    for (int i = 0; i < LANE_NUM; i++) begin
      logic [ELEN-1:0] r;
      logic [ELEN:0]   sum;
      if (bus.vec_operand_type == 2'b00) begin
        opa_s[i] = bus.vs1[i*ELEN +: ELEN] & sew_m_s;
      end else begin
        opa_s[i] = scalar_s & sew_m_s;
      end
      opb_s[i]    = bus.vs2[i*ELEN +: ELEN] & sew_m_s;
      opd_s[i]    = bus.vd_old[i*ELEN +: ELEN] & sew_m_s;
      active_s[i] = bus.vm || bus.mask[i] ||
                    (bus.opcode == VECTOR_ADC) || (bus.opcode == VECTOR_SBC);
      sum = {1'b0, opb_s[i]} + {1'b0, opa_s[i]};
      case (bus.opcode)
        VECTOR_ADD:  r = opb_s[i] + opa_s[i];
        VECTOR_SUB:  r = opb_s[i] - opa_s[i];
        VECTOR_ADC:  r = opb_s[i] + opa_s[i] + {{(ELEN-1){1'b0}}, bus.mask[i]};
        VECTOR_SBC:  r = opb_s[i] - opa_s[i] - {{(ELEN-1){1'b0}}, bus.mask[i]};
        VECTOR_MADC: r = {{(ELEN-1){1'b0}}, sum[sew_bits_s]};
        VECTOR_MSBC: r = {{(ELEN-1){1'b0}}, (opb_s[i] < opa_s[i])};
`ifdef VECTOR_LANE_FAST_MUL_EN
        VECTOR_MACC:  r = opd_s[i] + opa_s[i] * opb_s[i];
        VECTOR_NMSAC: r = opd_s[i] - opa_s[i] * opb_s[i];
        VECTOR_MADD:  r = opa_s[i] * opd_s[i] + opb_s[i];
`endif
        default:     r = {ELEN{1'b0}};
      endcase
      r = r & sew_m_s;
      if (bus.is_mask_operation) begin
        r = {{(ELEN-1){1'b0}}, r[0]};
      end else begin
        r = r;
      end
      if (err_s) begin
        lane_res_s[i*ELEN +: ELEN] = {ELEN{1'b0}};
      end else if (active_s[i]) begin
        lane_res_s[i*ELEN +: ELEN] = r;
      end else if (bus.is_mask_operation) begin
        lane_res_s[i*ELEN +: ELEN] = {{(ELEN-1){1'b0}}, bus.vd_old[i*ELEN]};
      end else begin
        lane_res_s[i*ELEN +: ELEN] = bus.vd_old[i*ELEN +: ELEN];
      end
    end
  end

  // Control FSM next state, result capture and shift-add multiplier step
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    err_d    = err_q;
`ifndef VECTOR_LANE_FAST_MUL_EN
    cnt_d    = cnt_q;
    active_d = active_q;
    vd_old_d = vd_old_q;
    sew_m_d  = sew_m_q;
    neg_d    = neg_q;
    mop_d    = mop_q;
    for (int i = 0; i < LANE_NUM; i++) begin
      mcand_d[i]  = mcand_q[i];
      mplier_d[i] = mplier_q[i];
      acc_d[i]    = acc_q[i];
    end
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
        if (accept_s) begin
          state_d  = S_DONE;
          result_d = lane_res_s;
          err_d    = err_s;
`ifndef VECTOR_LANE_FAST_MUL_EN
          if (is_mul_s && !err_s) begin
            state_d  = S_MUL;
            cnt_d    = sew_bits_s - 7'd1;
            active_d = active_s;
            vd_old_d = bus.vd_old;
            sew_m_d  = sew_m_s;
            neg_d    = (bus.opcode == VECTOR_NMSAC);
            mop_d    = bus.is_mask_operation;
            // MADD multiplies by vd_old and adds vs2; the others multiply vs2 into vd_old
            for (int i = 0; i < LANE_NUM; i++) begin
              mcand_d[i]  = opa_s[i];
              mplier_d[i] = (bus.opcode == VECTOR_MADD) ? opd_s[i] : opb_s[i];
              acc_d[i]    = (bus.opcode == VECTOR_MADD) ? opb_s[i] : opd_s[i];
            end
          end else begin
            cnt_d = cnt_q;
          end
`endif
        end else begin
          result_d = result_q;
        end
      end
`ifndef VECTOR_LANE_FAST_MUL_EN
      S_MUL: begin
        cnt_d = cnt_q - 7'd1;
        for (int i = 0; i < LANE_NUM; i++) begin
          logic [ELEN-1:0] fin;
          if (mplier_q[i][0]) begin
            acc_d[i] = neg_q ? (acc_q[i] - mcand_q[i]) : (acc_q[i] + mcand_q[i]);
          end else begin
            acc_d[i] = acc_q[i];
          end
          mcand_d[i]  = mcand_q[i] << 1;
          mplier_d[i] = mplier_q[i] >> 1;
          fin = acc_d[i] & sew_m_q;
          if (mop_q) begin
            fin = {{(ELEN-1){1'b0}}, fin[0]};
          end else begin
            fin = fin;
          end
          if (active_q[i]) begin
            result_d[i*ELEN +: ELEN] = fin;
          end else if (mop_q) begin
            result_d[i*ELEN +: ELEN] = {{(ELEN-1){1'b0}}, vd_old_q[i*ELEN]};
          end else begin
            result_d[i*ELEN +: ELEN] = vd_old_q[i*ELEN +: ELEN];
          end
        end
        if (cnt_q == 7'd0) begin
          state_d = S_DONE;
          err_d   = 1'b0;
        end else begin
          state_d = S_MUL;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= {(LANE_NUM*ELEN){1'b0}};
      err_q    <= 1'b0;
`ifndef VECTOR_LANE_FAST_MUL_EN
      cnt_q    <= 7'd0;
      active_q <= {LANE_NUM{1'b0}};
      vd_old_q <= {(LANE_NUM*ELEN){1'b0}};
      sew_m_q  <= {ELEN{1'b0}};
      neg_q    <= 1'b0;
      mop_q    <= 1'b0;
      for (int i = 0; i < LANE_NUM; i++) begin
        mcand_q[i]  <= {ELEN{1'b0}};
        mplier_q[i] <= {ELEN{1'b0}};
        acc_q[i]    <= {ELEN{1'b0}};
      end
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      err_q    <= err_d;
`ifndef VECTOR_LANE_FAST_MUL_EN
      cnt_q    <= cnt_d;
      active_q <= active_d;
      vd_old_q <= vd_old_d;
      sew_m_q  <= sew_m_d;
      neg_q    <= neg_d;
      mop_q    <= mop_d;
      for (int i = 0; i < LANE_NUM; i++) begin
        mcand_q[i]  <= mcand_d[i];
        mplier_q[i] <= mplier_d[i];
        acc_q[i]    <= acc_d[i];
      end
`endif
    end
  end
endmodule

// File: tb/tb_vector_lane_array_alu.sv
// Table-driven, scoreboarded bench for vector_lane_array_alu (4 lanes x 64 bits).
module tb_vector_lane_array_alu;
  localparam int LN = 4;
  localparam int EL = 64;
  localparam int LW = 32;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000010;
  localparam logic [5:0] OP_ADC   = 6'b010000;
  localparam logic [5:0] OP_MADC  = 6'b010001;
  localparam logic [5:0] OP_SBC   = 6'b010010;
  localparam logic [5:0] OP_MSBC  = 6'b010011;
  localparam logic [5:0] OP_MADD  = 6'b101001;
  localparam logic [5:0] OP_MACC  = 6'b101101;
  localparam logic [5:0] OP_NMSAC = 6'b101111;
  localparam logic [1:0] VV = 2'b00, VX = 2'b01, VI = 2'b10;

  typedef struct {
    logic [5:0]   op;
    logic [2:0]   sew;
    logic         vm;
    logic [1:0]   vt;
    logic         mop;
    logic [3:0]   mask;
    logic [255:0] vs1, vs2, vd;
    logic [31:0]  imm, rs;
    logic [255:0] exp;
    logic         err;
  } vec_t;

  typedef struct {
    logic [255:0] res;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];
  vec_t tbl[16];
  vec_t v;

  always #5 clk = ~clk;

  vector_lane_array_alu_if #(.LANE_NUM(LN), .ELEN(EL), .LEN(LW)) bus ();
  vector_lane_array_alu #(.LANE_NUM(LN), .ELEN(EL), .LEN(LW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  function automatic logic [255:0] rep(input logic [63:0] x);
    return {x, x, x, x};
  endfunction

  function automatic vec_t mk(input logic [5:0] op, input logic [2:0] sew, input logic vm,
                              input logic [1:0] vt, input logic mop, input logic [3:0] mask,
                              input logic [255:0] vs1, input logic [255:0] vs2,
                              input logic [255:0] vd, input logic [31:0] imm,
                              input logic [31:0] rs, input logic [255:0] exp,
                              input logic err);
    vec_t r;
    r.op = op; r.sew = sew; r.vm = vm; r.vt = vt; r.mop = mop; r.mask = mask;
    r.vs1 = vs1; r.vs2 = vs2; r.vd = vd; r.imm = imm; r.rs = rs; r.exp = exp; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic issue(input vec_t t, input bit track);
    int n;
    bus.opcode = t.op; bus.vsew = t.sew; bus.vm = t.vm; bus.vec_operand_type = t.vt;
    bus.is_mask_operation = t.mop; bus.mask = t.mask; bus.vs1 = t.vs1; bus.vs2 = t.vs2;
    bus.vd_old = t.vd; bus.imm = t.imm; bus.rs = t.rs; bus.in_valid = 1'b1;
    if (track) sb_q.push_back('{t.exp, t.err});
    n = 0;
    #1;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept", {255'd0, bus.in_ready}, 256'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard: every output handshake must match the oldest pending expectation
  always begin
    @(negedge clk);
    #3;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_out_valid: got result %0h want no output", bus.result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", bus.result, e.res);
        chk("out_error", {255'd0, bus.out_error}, {255'd0, e.err});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.opcode = 6'd0; bus.vsew = 3'd0;
    bus.vm = 1'b1; bus.vec_operand_type = 2'b00; bus.is_mask_operation = 1'b0;
    bus.mask = 4'h0; bus.vs1 = 256'd0; bus.vs2 = 256'd0; bus.vd_old = 256'd0;
    bus.imm = 32'd0; bus.rs = 32'd0;

    tbl[0]  = mk(OP_ADD, 3'd0, 1'b1, VV, 1'b0, 4'h0,
                 {64'h1, 64'h7F, 64'hFFFF_FF01, 64'hF0}, {64'h2, 64'h01, 64'hFF, 64'h20},
                 256'd0, 32'd0, 32'd0, {64'h3, 64'h80, 64'h0, 64'h10}, 1'b0);
    tbl[1]  = mk(OP_SUB, 3'd3, 1'b1, VX, 1'b0, 4'h0, rep(64'h1234), {64'h0, 64'h0, 64'h5, 64'h0},
                 256'd0, 32'd0, 32'hFFFF_FFFF, {64'h1, 64'h1, 64'h6, 64'h1}, 1'b0);
    tbl[2]  = mk(OP_MADC, 3'd2, 1'b1, VV, 1'b1, 4'h0,
                 {64'hFFFF_FFFF_8000_0000, 64'h8000_0000, 64'h1, 64'h8000_0000},
                 {64'h8000_0000, 64'h8000_0000, 64'h1, 64'h8000_0000},
                 256'd0, 32'd0, 32'd0, {64'h1, 64'h1, 64'h0, 64'h1}, 1'b0);
    tbl[3]  = mk(OP_MSBC, 3'd0, 1'b0, VV, 1'b1, 4'b0011, {64'h0, 64'h0, 64'h6, 64'h4},
                 {64'h0, 64'h0, 64'h5, 64'h5}, {64'hFF, 64'hFE, 64'h0, 64'h0},
                 32'd0, 32'd0, {64'h1, 64'h0, 64'h1, 64'h0}, 1'b0);
    tbl[4]  = mk(OP_ADC, 3'd1, 1'b0, VV, 1'b0, 4'b1010, 256'd0, rep(64'h1234_FFFF),
                 rep(64'hAAAA), 32'd0, 32'd0, {64'h0, 64'hFFFF, 64'h0, 64'hFFFF}, 1'b0);
    tbl[5]  = mk(OP_SBC, 3'd2, 1'b0, VV, 1'b0, 4'b0001, 256'd0, 256'd0, rep(64'h5),
                 32'd0, 32'd0, {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF}, 1'b0);
    tbl[6]  = mk(OP_ADD, 3'd2, 1'b0, VI, 1'b0, 4'b0110, rep(64'h77), rep(64'h5),
                 {64'hDEAD_BEEF_0000_0003, 64'h9, 64'h9, 64'hCAFE_F00D_0000_0000},
                 32'hFFFF_FFFE, 32'd0,
                 {64'hDEAD_BEEF_0000_0003, 64'h3, 64'h3, 64'hCAFE_F00D_0000_0000}, 1'b0);
    tbl[7]  = mk(OP_ADD, 3'b111, 1'b1, VV, 1'b0, 4'h0, rep(64'h1), rep(64'h1), rep(64'h9),
                 32'd0, 32'd0, 256'd0, 1'b1);
    tbl[8]  = mk(6'b111111, 3'd0, 1'b1, VV, 1'b0, 4'h0, rep(64'h1), rep(64'h1), rep(64'h9),
                 32'd0, 32'd0, 256'd0, 1'b1);
    tbl[9]  = mk(OP_ADD, 3'd0, 1'b1, VX, 1'b0, 4'h0, 256'd0, rep(64'h1), 256'd0,
                 32'd0, 32'h0000_0180, rep(64'h81), 1'b0);
    tbl[10] = mk(OP_ADD, 3'd3, 1'b1, VX, 1'b0, 4'h0, 256'd0, 256'd0, 256'd0,
                 32'd0, 32'h8000_0000, rep(64'hFFFF_FFFF_8000_0000), 1'b0);
    tbl[11] = mk(OP_MACC, 3'd1, 1'b0, VV, 1'b0, 4'b0101, rep(64'h3), rep(64'h5), rep(64'h7),
                 32'd0, 32'd0, {64'h7, 64'h16, 64'h7, 64'h16}, 1'b0);
    tbl[12] = mk(OP_NMSAC, 3'd0, 1'b1, VV, 1'b0, 4'h0, rep(64'h3), rep(64'h7), rep(64'h10),
                 32'd0, 32'd0, rep(64'hFB), 1'b0);
    tbl[13] = mk(OP_MADD, 3'd2, 1'b1, VV, 1'b0, 4'h0, rep(64'h10000), rep(64'h5),
                 rep(64'h10000), 32'd0, 32'd0, rep(64'h5), 1'b0);
    tbl[14] = mk(OP_MACC, 3'd3, 1'b1, VV, 1'b0, 4'h0, rep(64'hFFFF_FFFF_FFFF_FFFF), rep(64'h2),
                 {64'h0, 64'h0, 64'hA, 64'h0}, 32'd0, 32'd0,
                 {64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8,
                  64'hFFFF_FFFF_FFFF_FFFE}, 1'b0);
    tbl[15] = mk(OP_MACC, 3'd2, 1'b1, VX, 1'b0, 4'h0, 256'd0, rep(64'h3), rep(64'hA),
                 32'd0, 32'hFFFF_FFFF, rep(64'h7), 1'b0);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", {255'd0, bus.in_ready}, 256'd1);
    chk("rst_out_valid", {255'd0, bus.out_valid}, 256'd0);
    chk("rst_busy", {255'd0, bus.busy}, 256'd0);
    chk("rst_out_error", {255'd0, bus.out_error}, 256'd0);
    chk("rst_result", bus.result, 256'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) issue(tbl[i], 1'b1);
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("drain_table", 256'(sb_q.size()), 256'd0);

    // Latency: 1 cycle for ALU ops, SEW+1 for multiply-accumulate
    issue(tbl[0], 1'b1);
    n = 1;
    while (!bus.out_valid && n < 200) begin @(negedge clk); n++; end
    chk("lat_add", 256'(n), 256'd1);
    issue(tbl[11], 1'b1);
    n = 1;
    while (!bus.out_valid && n < 200) begin @(negedge clk); n++; end
    chk("lat_macc16", 256'(n), 256'd17);
    v = mk(OP_MACC, 3'd0, 1'b1, VV, 1'b0, 4'h0, rep(64'h2), rep(64'h3), rep(64'h1),
           32'd0, 32'd0, rep(64'h7), 1'b0);
    issue(v, 1'b1);
    n = 1;
    while (!bus.out_valid && n < 200) begin @(negedge clk); n++; end
    chk("lat_macc8", 256'(n), 256'd9);
    @(negedge clk);

    // Backpressure: result held stable, then accept a new request on the release cycle
    bus.out_ready = 1'b0;
    issue(tbl[9], 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", {255'd0, bus.out_valid}, 256'd1);
      chk("bp_result", bus.result, rep(64'h81));
      chk("bp_in_ready", {255'd0, bus.in_ready}, 256'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {255'd0, bus.in_ready}, 256'd1);
    issue(tbl[1], 1'b1);
    chk("no_bubble_valid", {255'd0, bus.out_valid}, 256'd1);
    chk("no_bubble_result", bus.result, {64'h1, 64'h1, 64'h6, 64'h1});
    @(negedge clk);

    // Reset mid-multiply abandons the operation
    issue(tbl[14], 1'b0);
    repeat (30) @(negedge clk);
    chk("mul_busy", {255'd0, bus.busy}, 256'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mrst_out_valid", {255'd0, bus.out_valid}, 256'd0);
    chk("mrst_in_ready", {255'd0, bus.in_ready}, 256'd1);
    chk("mrst_busy", {255'd0, bus.busy}, 256'd0);
    chk("mrst_result", bus.result, 256'd0);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    chk("final_drain", 256'(sb_q.size()), 256'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vector_lane_array_alu.md
Name: vector_lane_array_alu

Overview:
- Parametrised successor to the single-lane vector ALU: LANE_NUM lanes of ELEN-bit integer datapath share one control FSM and a valid/ready handshake.
- Adds the multiply-accumulate family (MACC/NMSAC/MADD) via an iterative shift-add multiplier.
- Masked-off elements keep their old destination value (undisturbed) instead of being zeroed.
- Sits between vector issue and vector register writeback; one instruction beat (LANE_NUM elements) in flight at a time.

Parameters:
- LANE_NUM, 4, number of parallel lanes (elements per beat).
- ELEN, 64, maximum element width in bits; supported SEW is 8/16/32/64 and must not exceed ELEN.
- LEN, 32, width of the scalar imm/rs operands.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request this cycle
- vsew  in  3  element width, using the ONE_BYTE/TWO_BYTE/FOUR_BYTE/EIGHT_BYTE macros from defines.v
- vm  in  1  1 = unmasked
- opcode  in  6  operation, using the VECTOR_* opcode macros from defines.v
- vec_operand_type  in  2  vs1 source: 00 = vector (VV), 01 = rs (VX), 10 = imm (VI)
- is_mask_operation  in  1  result is a 1-bit mask per lane
- mask  in  LANE_NUM  v0 mask bit per lane
- vs1, vs2, vd_old  in  LANE_NUM*ELEN  operands; lane i occupies bits [i*ELEN +: ELEN]
- imm, rs  in  LEN  scalar operands, already sign-extended to LEN
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- result  out  LANE_NUM*ELEN  per-lane result
- out_error  out  1  unsupported opcode or vsew; qualified by out_valid
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous) values: state IDLE, in_ready=1, out_valid=0, result=0, out_error=0, busy=0, iteration counter=0.
- Reset asserted mid-operation abandons the operation: no out_valid is produced for it.
- Request capture: a request is accepted when in_valid && in_ready. On acceptance, all inputs are registered. When vec_operand_type is VX/VI, rs/imm is sign-extended (SEW > LEN) or truncated (SEW <= LEN) to SEW and broadcast to every lane.
- in_ready = (state==IDLE) || (state==DONE && out_ready), so back-to-back operation is possible with no bubble.
- Lane activity: a lane is active when vm || mask[i]. An inactive lane outputs vd_old[i] unchanged.
- ADC/SBC ignore the active rule and always use mask[i] as carry-in/borrow-in.
- FSM states IDLE, MUL, DONE:
  - IDLE -> DONE on acceptance of a non-multiply op; the result is registered in the same edge, giving latency 1.
  - IDLE -> MUL on acceptance of MACC/NMSAC/MADD; the counter is loaded with SEW-1.
  - MUL: each cycle, every lane adds (multiplicand << k) into its accumulator when multiplier bit k is 1. The counter decrements each cycle. MUL -> DONE on the cycle the counter reaches 0. Total latency is SEW+1 cycles from acceptance to out_valid (9/17/33/65).
  - DONE: out_valid=1, and result and out_error are held stable until out_ready. On out_ready: go to IDLE, or capture a new request in the same cycle and go directly to MUL/DONE as above.
- Arithmetic, modulo 2^SEW, with result bits above SEW zero:
  - ADD: vs2+vs1. SUB: vs2-vs1.
  - ADC: vs2+vs1+mask. SBC: vs2-vs1-mask.
  - MADC: carry-out of vs2+vs1, unsigned. MSBC: borrow of vs2-vs1, i.e. vs2<vs1 unsigned.
  - MACC: vd_old + vs1*vs2. NMSAC: vd_old - vs1*vs2. MADD: vs1*vd_old + vs2.
  - Only the low SEW bits of each product are kept.
- When is_mask_operation=1, lane result = {0, bit}. An inactive lane outputs vd_old[i][0] in bit 0 and zeros above.
- Unsupported opcode, or vsew not legal/greater than ELEN: the request takes the 1-cycle path; result=0 and out_error=1.
- out_valid never asserts without a preceding acceptance; each accepted request produces exactly one out_valid handshake.

Optional Feature:
- Macro: VECTOR_LANE_FAST_MUL_EN.
- Defined: multiply ops use a combinational ELEN x ELEN per-lane product and take the 1-cycle path (IDLE -> DONE). The MUL state and counter are not compiled.
- Undefined: the iterative MUL path is used, with latency SEW+1 as specified above.
- Results are bit-identical in both builds; only latency differs.

Test Plan:
- VV ADD, SEW=8, vm=1, lane0 vs1=0xF0, vs2=0x20 -> after 1 cycle out_valid=1 and lane0 result=0x10 (wrapped), bits above 8 zero.
- VX SUB, SEW=64, rs=0xFFFFFFFF, vs2=0 -> result=0x0000000000000001 (rs sign-extended to -1).
- MACC, SEW=16, vs1=3, vs2=5, vd_old=7, mask=4'b0101, vm=0 -> out_valid exactly 17 cycles after acceptance; lanes 0 and 2 = 22, lanes 1 and 3 = vd_old.
- MADC with is_mask_operation=1, SEW=32, vs1=vs2=0x80000000 -> result=1; with vs1=vs2=1 -> result=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable and in_ready=0. Then raise out_ready together with a new in_valid -> new request accepted that cycle, with no idle cycle.
- Reset asserted during MUL (SEW=64, counter mid-way) -> next cycle state IDLE, out_valid=0, in_ready=1. Invalid vsew 3'b111 -> out_error=1 with result=0.
